secuenciador_principal: RTL and testbench



---
 rtl/secuenciador_principal.sv | 120 ++++++++++++
 tb/tb_secuenciador_principal.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_principal.sv
// Slot sequencer: walks ESTADO through the slots of a pass, requesting one bus
// transaction per slot, with per-slot acknowledge timeout, abort and sticky error.
module secuenciador_principal #(
  parameter int         ESPERA_MAX = 16,
  parameter logic [4:0] ESTADO_FIN = 5'd19
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INICIAR,
  input  logic       MODO,
  input  logic       ABORTAR,
  input  logic       LISTO_BUS,
  output logic       PEDIDO_BUS,
  output logic [4:0] ESTADO,
  output logic       OCUPADO,
  output logic       FIN,
  output logic       ERROR
);

  typedef enum logic [2:0] {
    REPOSO,
    ESPERAR,
    AVANZAR,
    TERMINAR,
    FALLA
  } fase_t;

  localparam logic [7:0] LIMITE   = 8'(ESPERA_MAX - 1);
  localparam logic [4:0] SLOT_CFG = 5'd16;
  // A configuration pass never starts beyond the last slot.
  localparam logic [4:0] INI_CFG  = (SLOT_CFG > ESTADO_FIN) ? ESTADO_FIN : SLOT_CFG;

  fase_t      fase_q, fase_d;
  logic [4:0] slot_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fase_q     <= REPOSO;
      ESTADO     <= ESTADO_FIN;
      cnt_q      <= '0;
      ERROR      <= 1'b0;
      PEDIDO_BUS <= 1'b0;
      OCUPADO    <= 1'b0;
      FIN        <= 1'b0;
    end else begin
      fase_q     <= fase_d;
      ESTADO     <= slot_d;
      cnt_q      <= cnt_d;
      ERROR      <= err_d;
      // Outputs are flops decoded from the next phase, so they track fase_q exactly.
      PEDIDO_BUS <= (fase_d == ESPERAR);
      OCUPADO    <= (fase_d != REPOSO);
      FIN        <= (fase_d == TERMINAR);
    end
  end

  always_comb begin
    fase_d = fase_q;
    slot_d = ESTADO;
    cnt_d  = cnt_q;
    err_d  = ERROR;
    unique case (fase_q)
      REPOSO: begin
        slot_d = ESTADO_FIN;
        if (INICIAR && !ABORTAR) begin
          fase_d = ESPERAR;
          slot_d = MODO ? INI_CFG : 5'd0;
          err_d  = 1'b0;
          cnt_d  = '0;
        end
      end
      ESPERAR: begin
        // Priority: abort, then acknowledge, then timeout.
        if (ABORTAR) begin
          fase_d = REPOSO;
          slot_d = ESTADO_FIN;
          cnt_d  = '0;
        end else if (LISTO_BUS) begin
          fase_d = AVANZAR;
          cnt_d  = '0;
        end else if (cnt_q == LIMITE) begin
          fase_d = FALLA;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      AVANZAR: begin
        cnt_d = '0;
        if (ABORTAR) begin
          fase_d = REPOSO;
          slot_d = ESTADO_FIN;
        end else if (ESTADO >= ESTADO_FIN) begin
          fase_d = TERMINAR;
          slot_d = ESTADO_FIN;
        end else begin
          fase_d = ESPERAR;
          slot_d = ESTADO + 5'd1;
        end
      end
      TERMINAR: begin
        fase_d = REPOSO;
        slot_d = ESTADO_FIN;
      end
      FALLA: begin
        fase_d = REPOSO;
        slot_d = ESTADO_FIN;
        cnt_d  = '0;
      end
      default: begin
        fase_d = REPOSO;
        slot_d = ESTADO_FIN;
        cnt_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_secuenciador_principal.sv
// Directed bench for secuenciador_principal: full/config passes, timeout,
// ack-at-timeout, abort, ignored restart and mid-pass reset.
module tb_secuenciador_principal;

  logic       CLK = 1'b0;
  logic       RST, INICIAR, MODO, ABORTAR, LISTO_BUS;
  logic       PEDIDO_BUS, OCUPADO, FIN, ERROR;
  logic [4:0] ESTADO;

  int vectors = 0;
  int miscompares = 0;
  int nreq = 0, nfin = 0, over = 0;
  logic ped_prev = 1'b0;

  secuenciador_principal #(.ESPERA_MAX(16), .ESTADO_FIN(5'd19)) dut (
    .CLK(CLK), .RST(RST), .INICIAR(INICIAR), .MODO(MODO), .ABORTAR(ABORTAR),
    .LISTO_BUS(LISTO_BUS), .PEDIDO_BUS(PEDIDO_BUS), .ESTADO(ESTADO),
    .OCUPADO(OCUPADO), .FIN(FIN), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  // Independent monitor: request rising edges, FIN pulses, slot overrun.
  always @(negedge CLK) begin
    if (PEDIDO_BUS === 1'b1 && ped_prev !== 1'b1) nreq++;
    ped_prev = PEDIDO_BUS;
    if (FIN === 1'b1) nfin++;
    if (ESTADO > 5'd19) over++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack_slot();
    LISTO_BUS = 1'b1;
    tick();
    LISTO_BUS = 1'b0;
    tick();
  endtask

  task automatic run_pass(input logic modo, input int delay);
    int r0, f0, first;
    r0 = nreq;
    f0 = nfin;
    first = modo ? 16 : 0;
    MODO = modo;
    INICIAR = 1'b1;
    tick();
    INICIAR = 1'b0;
    for (int s = first; s <= 19; s++) begin
      chk("paso_estado", ESTADO, s);
      chk("paso_pedido", PEDIDO_BUS, 1);
      repeat (delay) tick();
      LISTO_BUS = 1'b1;
      tick();
      LISTO_BUS = 1'b0;
      chk("avanzar_pedido", PEDIDO_BUS, 0);
      chk("avanzar_fin", FIN, 0);
      tick();
    end
    chk("fin_pulso", FIN, 1);
    chk("fin_estado", ESTADO, 19);
    chk("fin_ocupado", OCUPADO, 1);
    tick();
    chk("post_fin", FIN, 0);
    chk("post_ocupado", OCUPADO, 0);
    chk("post_estado", ESTADO, 19);
    chk("post_error", ERROR, 0);
    chk("n_pedidos", nreq - r0, modo ? 4 : 20);
    chk("n_fin", nfin - f0, 1);
  endtask

  initial begin
    int cyc, f0;
    RST = 1'b1; INICIAR = 1'b0; MODO = 1'b0; ABORTAR = 1'b0; LISTO_BUS = 1'b0;
    tick();
    tick();
    chk("rst_pedido", PEDIDO_BUS, 0);
    chk("rst_estado", ESTADO, 19);
    chk("rst_ocupado", OCUPADO, 0);
    chk("rst_fin", FIN, 0);
    chk("rst_error", ERROR, 0);
    RST = 1'b0;
    tick();

    // Full pass, ack one cycle after each request; then config pass, immediate acks.
    run_pass(1'b0, 1);
    run_pass(1'b1, 0);

    // Timeout at slot 5.
    MODO = 1'b0; INICIAR = 1'b1;
    tick();
    INICIAR = 1'b0;
    repeat (5) ack_slot();
    chk("to_slot", ESTADO, 5);
    cyc = 0;
    while (PEDIDO_BUS === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("to_ciclos_pedido", cyc, 16);
    chk("falla_error", ERROR, 1);
    chk("falla_estado", ESTADO, 5);
    chk("falla_ocupado", OCUPADO, 1);
    tick();
    chk("to_error", ERROR, 1);
    chk("to_ocupado", OCUPADO, 0);
    chk("to_estado", ESTADO, 19);
    LISTO_BUS = 1'b1;                    // ack while idle must be ignored
    tick();
    tick();
    LISTO_BUS = 1'b0;
    chk("reposo_listo_pedido", PEDIDO_BUS, 0);
    chk("error_pegajoso", ERROR, 1);

    // Restart clears ERROR; ack in the 16th waiting cycle of slot 3 wins.
    INICIAR = 1'b1;
    tick();
    INICIAR = 1'b0;
    chk("reinicio_error", ERROR, 0);
    chk("reinicio_estado", ESTADO, 0);
    repeat (3) ack_slot();
    chk("lim_slot", ESTADO, 3);
    repeat (15) tick();
    chk("lim_pedido_aun", PEDIDO_BUS, 1);
    LISTO_BUS = 1'b1;
    tick();
    LISTO_BUS = 1'b0;
    chk("lim_avanzar_pedido", PEDIDO_BUS, 0);
    chk("lim_error", ERROR, 0);
    tick();
    chk("lim_estado_sig", ESTADO, 4);
    chk("lim_pedido_sig", PEDIDO_BUS, 1);

    // INICIAR mid-pass ignored, then abort with simultaneous ack at slot 10.
    repeat (2) ack_slot();
    INICIAR = 1'b1; MODO = 1'b1;
    tick();
    INICIAR = 1'b0; MODO = 1'b0;
    chk("ignora_iniciar_estado", ESTADO, 6);
    chk("ignora_iniciar_pedido", PEDIDO_BUS, 1);
    repeat (4) ack_slot();
    chk("ab_slot", ESTADO, 10);
    f0 = nfin;
    ABORTAR = 1'b1; LISTO_BUS = 1'b1;
    tick();
    ABORTAR = 1'b0; LISTO_BUS = 1'b0;
    chk("ab_pedido", PEDIDO_BUS, 0);
    chk("ab_estado", ESTADO, 19);
    chk("ab_ocupado", OCUPADO, 0);
    chk("ab_error", ERROR, 0);
    tick();
    tick();
    chk("ab_sin_fin", nfin - f0, 0);
    chk("ab_reposo", OCUPADO, 0);

    // ABORTAR blocks acceptance of INICIAR in REPOSO.
    INICIAR = 1'b1; ABORTAR = 1'b1;
    tick();
    INICIAR = 1'b0; ABORTAR = 1'b0;
    chk("ab_inicio_ocupado", OCUPADO, 0);
    chk("ab_inicio_pedido", PEDIDO_BUS, 0);

    // Reset at slot 7 dominates every input.
    INICIAR = 1'b1;
    tick();
    INICIAR = 1'b0;
    repeat (7) ack_slot();
    chk("rm_slot", ESTADO, 7);
    RST = 1'b1; INICIAR = 1'b1; LISTO_BUS = 1'b1;
    tick();
    RST = 1'b0; INICIAR = 1'b0; LISTO_BUS = 1'b0;
    chk("rm_pedido", PEDIDO_BUS, 0);
    chk("rm_estado", ESTADO, 19);
    chk("rm_ocupado", OCUPADO, 0);
    chk("rm_fin", FIN, 0);
    chk("rm_error", ERROR, 0);
    run_pass(1'b0, 0);

    // RST clears a sticky ERROR.
    INICIAR = 1'b1;
    tick();
    INICIAR = 1'b0;
    cyc = 0;
    while (PEDIDO_BUS === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("to0_ciclos", cyc, 16);
    tick();
    chk("to0_error", ERROR, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_borra_error", ERROR, 0);

    chk("estado_max", over, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
